// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the iterative RV32M divider (package div_pkg).
package div_pkg;

    localparam int unsigned DIV_N     = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_N + 1);

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINAL
    } div_state_e;

    // funct3[0] clear means the operands are two's-complement
    function automatic logic op_is_signed(input div_op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle between the EX stage and the divider.
interface seq_divider_if #(
    parameter int unsigned N = 32
);
    logic         start;
    logic         kill;
    logic [1:0]   op;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         ready;
    logic         busy;
    logic         done;
    logic [N-1:0] result;

    modport master (
        output start, kill, op, A, B,
        input  ready, busy, done, result
    );

    modport slave (
        input  start, kill, op, A, B,
        output ready, busy, done, result
    );
endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] rem,
    input  logic         dbit,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_next,
    output logic         qbit
);
    logic [N:0] partial;
    logic [N:0] diff;

    always_comb begin
        partial  = {rem, dbit};
        diff     = partial - {1'b0, divisor};
        qbit     = (partial >= {1'b0, divisor});
        // rem < divisor on entry, so whichever value is kept fits in N bits
        rem_next = qbit ? diff[N-1:0] : partial[N-1:0];
    end
endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
// Optional macro DIV_EARLY_EXIT_EN: divide-by-zero and signed overflow skip the iterations.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned N = DIV_N
) (
    input  logic           clk,
    input  logic           reset,
    seq_divider_if.slave   bus
);
    localparam int unsigned     CNT_W    = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N);
    localparam logic [N-1:0]    MIN_NEG  = {1'b1, {(N-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q;
    div_op_e          op_q;
    logic [N-1:0]     quo_q, rem_q, div_q, a_q, result_q;
    logic             q_neg_q, r_neg_q, div_zero_q, ovf_q;

    div_op_e          op_in;
    logic             accept, in_signed, a_neg, b_neg, in_div_zero, in_ovf;
    logic [N-1:0]     a_abs, b_abs;
    logic [N-1:0]     q_fix, r_fix, final_val;
    logic [N-1:0]     step_rem;
    logic             step_q;
`ifdef DIV_EARLY_EXIT_EN
    logic             in_special;
`endif

    always_comb begin
        op_in       = div_op_e'(bus.op);
        accept      = bus.start & ~bus.kill;
        in_signed   = op_is_signed(op_in);
        a_neg       = in_signed & bus.A[N-1];
        b_neg       = in_signed & bus.B[N-1];
        a_abs       = a_neg ? ('0 - bus.A) : bus.A;
        b_abs       = b_neg ? ('0 - bus.B) : bus.B;
        in_div_zero = (bus.B == '0);
        in_ovf      = in_signed && (bus.A == MIN_NEG) && (bus.B == '1);
`ifdef DIV_EARLY_EXIT_EN
        in_special  = in_div_zero | in_ovf;
`endif
    end

    div_step #(.N(N)) u_step (
        .rem      (rem_q),
        .dbit     (quo_q[N-1]),
        .divisor  (div_q),
        .rem_next (step_rem),
        .qbit     (step_q)
    );

    always_comb begin
        q_fix = q_neg_q ? ('0 - quo_q) : quo_q;
        r_fix = r_neg_q ? ('0 - rem_q) : rem_q;
        if (div_zero_q) begin
            q_fix = '1;
            r_fix = a_q;
        end else if (ovf_q) begin
            q_fix = a_q;
            r_fix = '0;
        end
        final_val = op_q[1] ? r_fix : q_fix;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FINAL is the done cycle; the result is registered on the CALC edge that leaves count==N
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC: begin
                if (bus.kill)                 state_d = IDLE;
                else if (count_q == CNT_LAST) state_d = FINAL;
            end
            FINAL:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            op_q       <= DIV;
            quo_q      <= '0;
            rem_q      <= '0;
            div_q      <= '0;
            a_q        <= '0;
            result_q   <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (accept) begin
                    op_q       <= op_in;
                    q_neg_q    <= a_neg ^ b_neg;
                    r_neg_q    <= a_neg;
                    quo_q      <= a_abs;
                    rem_q      <= '0;
                    div_q      <= b_abs;
                    a_q        <= bus.A;
                    div_zero_q <= in_div_zero;
                    ovf_q      <= in_ovf;
`ifdef DIV_EARLY_EXIT_EN
                    // special cases start at the last count so the next edge finalises
                    count_q    <= in_special ? CNT_LAST : '0;
`else
                    count_q    <= '0;
`endif
                end
                CALC: if (!bus.kill) begin
                    if (count_q == CNT_LAST) begin
                        result_q <= final_val;
                    end else begin
                        rem_q   <= step_rem;
                        quo_q   <= {quo_q[N-2:0], step_q};
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready  = (state_q == IDLE);
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == FINAL);
    assign bus.result = result_q;

endmodule
